// File: rtl/program_loader_if.sv
// Byte stream (sender -> loader) and instruction-memory write bus (loader -> memory).
// Each interface has a master modport for the driving side and a slave modport for the receiving side.
interface byte_stream_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, input  rx_ready);
    modport slave  (input  rx_valid, input  rx_data, output rx_ready);
endinterface

interface mem_wr_if #(parameter int ADDR_W = 8);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/program_loader.sv
// Boot loader: framed bytes -> big-endian 16-bit words written from address 0, write one cycle after the LO byte.
// Accepts one byte per cycle in IDLE..CSUM; rx_ready drops in DONE/ERROR until restart.
module program_loader #(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    byte_stream_if.slave  rx,
    mem_wr_if.master      wr,
    input  logic          restart,
    output logic          cpu_run,
    output logic          busy,
    output logic          error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int MAX_WORDS = 1 << ADDR_W;

    state_t            state_q, state_nxt;
    logic [7:0]        cnt_q;
    logic [7:0]        word_cnt_q;
    logic [7:0]        sum_q;
    logic [15:0]       data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_en_q;
    logic              rdy_q;
    logic              busy_q;
    logic              run_q;
    logic              err_q;

    logic accept;
    logic last_word;
    logic len_bad;

    assign accept    = rx.rx_valid & rdy_q;
    assign last_word = (word_cnt_q == (cnt_q - 8'd1));
    assign len_bad   = (rx.rx_data == 8'd0) || (32'(rx.rx_data) > 32'(MAX_WORDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            S_IDLE:  if (accept && rx.rx_data == SYNC) state_nxt = S_LEN;
            S_LEN:   if (accept) state_nxt = len_bad ? S_ERROR : S_HI;
            S_HI:    if (accept) state_nxt = S_LO;
            S_LO:    if (accept) state_nxt = last_word ? S_CSUM : S_HI;
            S_CSUM:  if (accept) state_nxt = (rx.rx_data == sum_q) ? S_DONE : S_ERROR;
            S_DONE:  if (restart) state_nxt = S_IDLE;
            S_ERROR: if (restart) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered status outputs; status is decoded from the next state
    // so every flag changes on the same edge as the state it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 8'd0;
            word_cnt_q <= 8'd0;
            sum_q      <= 8'd0;
            data_q     <= 16'd0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            rdy_q      <= 1'b1;
            busy_q     <= 1'b0;
            run_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (wr_en_q) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (accept) begin
                unique case (state_q)
                    S_LEN: begin
                        cnt_q      <= rx.rx_data;
                        sum_q      <= rx.rx_data;
                        word_cnt_q <= 8'd0;
                        addr_q     <= '0;
                    end
                    S_HI: begin
                        data_q[15:8] <= rx.rx_data;
                        sum_q        <= sum_q + rx.rx_data;
                    end
                    S_LO: begin
                        data_q[7:0] <= rx.rx_data;
                        sum_q       <= sum_q + rx.rx_data;
                        wr_en_q     <= 1'b1;
                        word_cnt_q  <= word_cnt_q + 8'd1;
                    end
                    default: begin
                    end
                endcase
            end
            rdy_q  <= !(state_nxt == S_DONE || state_nxt == S_ERROR);
            busy_q <= (state_nxt == S_LEN) || (state_nxt == S_HI) ||
                      (state_nxt == S_LO)  || (state_nxt == S_CSUM);
            run_q  <= (state_nxt == S_DONE);
            err_q  <= (state_nxt == S_ERROR);
        end
    end

    assign rx.rx_ready = rdy_q;
    assign wr.wr_en    = wr_en_q;
    assign wr.wr_addr  = addr_q;
    assign wr.wr_data  = data_q;
    assign cpu_run     = run_q;
    assign busy        = busy_q;
    assign error       = err_q;

endmodule
